// File: rtl/ram_fifo_pkg.sv
// Shared sizing constants for the RAM-backed FIFO controller.
// No logic; compile before any file that imports it.
// Defaults match the 1024x32 dual-port RAM behind the controller.
package ram_fifo_pkg;

  localparam int DEF_ADDR_W    = 10;
  localparam int DEF_DATA_W    = 32;
  localparam int RAM_DEPTH     = 1 << DEF_ADDR_W;
  localparam int OUT_BUF_DEPTH = 2;
  localparam int OUT_CNT_W     = $clog2(OUT_BUF_DEPTH + 1);

endpackage

// File: rtl/ram_fifo_out_buf.sv
// Purpose: 2-entry in-order holding buffer for words read out of the RAM.
// Latency: a word written at an edge is visible on out_data the following cycle.
// Backpressure: the caller must not write when full unless it pops in the same cycle.
module ram_fifo_out_buf
  import ram_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 pop,
  output logic                 out_valid,
  output logic [DATA_W-1:0]    out_data,
  output logic [OUT_CNT_W-1:0] out_cnt
);

  logic [DATA_W-1:0] mem [OUT_BUF_DEPTH];
  logic              wr_idx;
  logic              rd_idx;

  // Storage needs no reset: contents are only looked at while out_cnt > 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  // Ring indices and occupancy; write and pop together leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx  <= 1'b0;
      rd_idx  <= 1'b0;
      out_cnt <= '0;
    end else begin
      if (wr_en) begin
        wr_idx <= ~wr_idx;
      end
      if (pop) begin
        rd_idx <= ~rd_idx;
      end
      case ({wr_en, pop})
        2'b10:   out_cnt <= out_cnt + OUT_CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - OUT_CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  assign out_valid = (out_cnt != '0);
  assign out_data  = mem[rd_idx];

endmodule

// File: rtl/ram_fifo_ctrl_1024x32.sv
// Purpose: FIFO controller driving an external dual-port RAM (A write, B read) with a FWFT output.
// Latency: push to out_valid is 3 cycles when empty; 1 word/cycle sustained both ways.
// Backpressure: in_ready drops when the RAM holds 1024 words; reads stop when buffer+in-flight reach 2.
module ram_fifo_ctrl_1024x32
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              ram_weA,
  output logic [ADDR_W-1:0] ram_addrA,
  output logic [DATA_W-1:0] ram_dinA,
  output logic              ram_weB,
  output logic [ADDR_W-1:0] ram_addrB,
  output logic [DATA_W-1:0] ram_dinB,
  input  logic [DATA_W-1:0] ram_doutB
);

  localparam int              CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0] RAM_FULL = CNT_W'(1) << ADDR_W;

  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W-1:0]    rd_ptr;
  logic [CNT_W-1:0]     ram_cnt;
  logic                 inflight;
  logic [OUT_CNT_W-1:0] out_cnt;
  logic [OUT_CNT_W:0]   buf_occ;
  logic                 push;
  logic                 issue;
  logic                 pop;

  assign in_ready = !rst && (ram_cnt != RAM_FULL);
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // A read may be launched only if the word it returns is guaranteed a buffer slot,
  // counting the slot freed by a pop happening this same cycle.
  assign buf_occ = {1'b0, out_cnt} + {{OUT_CNT_W{1'b0}}, inflight};
  assign issue   = (ram_cnt != '0) &&
                   ((buf_occ - {{OUT_CNT_W{1'b0}}, pop}) < (OUT_CNT_W + 1)'(OUT_BUF_DEPTH));

  // Pointers, RAM occupancy and the in-flight flag; reset drops any pending read.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      case ({push, issue})
        2'b10:   ram_cnt <= ram_cnt + CNT_W'(1);
        2'b01:   ram_cnt <= ram_cnt - CNT_W'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      inflight <= issue;
    end
  end

  // RAM data from last cycle's issue lands in the output buffer.
  ram_fifo_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (inflight),
    .wr_data   (ram_doutB),
    .pop       (pop),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

  assign ram_weA   = push;
  assign ram_addrA = wr_ptr;
  assign ram_dinA  = in_data;
  assign ram_weB   = 1'b0;
  assign ram_addrB = rd_ptr;
  assign ram_dinB  = '0;

  assign count = ram_cnt + CNT_W'(inflight) + CNT_W'(out_cnt);
  assign full  = (ram_cnt == RAM_FULL);
  assign empty = (count == '0);

endmodule
